// File: rtl/fetch_align_pkg.sv
// Shared types and constants for the fetch/align block: halfword width,
// instruction-length encodings and the fetch FSM state type.
package fetch_align_pkg;

  localparam int HW_W = 16;

  // Instruction lengths in halfwords
  localparam logic [3:0] LEN16 = 4'd1;
  localparam logic [3:0] LEN32 = 4'd2;
  localparam logic [3:0] LEN64 = 4'd4;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fa_state_e;

  // Length is carried in the two top bits of the leading halfword
  function automatic logic [3:0] inst_len(input logic [1:0] top);
    case (top)
      2'b10:   inst_len = LEN32;
      2'b11:   inst_len = LEN64;
      default: inst_len = LEN16;
    endcase
  endfunction

endpackage

// File: rtl/fetch_align_if.sv
// Memory-fetch, redirect and decode-side signals of fetch_align.
// The master modport is the fetch_align side; slave is memory/decode.
interface fetch_align_if;

  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_data;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [63:0] inst_out;
  logic [63:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;

  modport master (
    output mem_req, mem_addr, inst_out, inst_pc, inst_valid,
    input  mem_ack, mem_data, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_req, mem_addr, inst_out, inst_pc, inst_valid,
    output mem_ack, mem_data, redirect, redirect_pc, inst_ready
  );

endinterface

// File: rtl/fetch_align_shiftbuf.sv
// fa_shiftbuf: 8-halfword instruction buffer, oldest halfword at the top.
// Positions at or beyond the valid count are kept zero so merges are plain ORs.
module fa_shiftbuf
  import fetch_align_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        consume_i,
  input  logic [3:0]  len_i,
  input  logic        fill_i,
  input  logic [63:0] fill_data_i,
  input  logic [1:0]  skip_i,
  output logic [63:0] window_o,
  output logic [3:0]  count_o
);

  logic [8*HW_W-1:0] buf_q, buf_d;
  logic [3:0]        count_q, count_d;
  logic [8*HW_W-1:0] shift_s;
  logic [3:0]        base_s;
  logic [63:0]       word_s;
  logic [2:0]        nfill_s;

  assign shift_s  = consume_i ? (buf_q << {len_i, 4'b0000}) : buf_q;
  assign base_s   = consume_i ? (count_q - len_i) : count_q;
  assign word_s   = fill_data_i << {skip_i, 4'b0000};
  assign nfill_s  = 3'd4 - {1'b0, skip_i};
  assign window_o = buf_q[8*HW_W-1 -: 64];
  assign count_o  = count_q;

  // Consume happens before the new word is appended at the post-consume count
  always_comb begin
    buf_d   = shift_s;
    count_d = base_s;
    if (clear_i) begin
      buf_d   = '0;
      count_d = 4'd0;
    end else if (fill_i) begin
      buf_d   = shift_s | ({word_s, 64'h0} >> {base_s, 4'b0000});
      count_d = base_s + {1'b0, nfill_s};
    end else begin
      buf_d   = shift_s;
      count_d = base_s;
    end
  end

  // Buffer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q   <= '0;
      count_q <= 4'd0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_align.sv
// fetch_align: fetches 8-byte words and presents left-justified variable-length
// instructions. Optional stall counter enabled by FETCH_ALIGN_STATS_EN.
module fetch_align
  import fetch_align_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_align_if.master bus
`ifdef FETCH_ALIGN_STATS_EN
  ,
  output logic [31:0]  stall_cnt
`endif
);

  localparam logic [63:0] RESET_ADDR = RESET_PC & ~64'h7;
  localparam logic [63:0] RESET_IPC  = RESET_PC & ~64'h1;

  fa_state_e   state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] pend_q, pend_d;
  logic [63:0] pc_q, pc_d;
  logic [1:0]  skip_q, skip_d;

  logic [63:0] window_s;
  logic [3:0]  count_s;
  logic [3:0]  len_s;
  logic        valid_s;
  logic        consume_s;
  logic [3:0]  count_after_s;
  logic        fill_s;
  logic [63:0] redir_pc_s;
  logic [63:0] redir_addr_s;

  assign len_s         = inst_len(window_s[63:62]);
  assign valid_s       = (count_s >= len_s) && !bus.redirect;
  assign consume_s     = valid_s && bus.inst_ready;
  assign count_after_s = consume_s ? (count_s - len_s) : count_s;
  assign fill_s        = (state_q == ST_WAIT) && bus.mem_ack && !bus.redirect;
  assign redir_pc_s    = bus.redirect_pc & ~64'h1;
  assign redir_addr_s  = bus.redirect_pc & ~64'h7;

  fa_shiftbuf u_shiftbuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (bus.redirect),
    .consume_i   (consume_s),
    .len_i       (len_s),
    .fill_i      (fill_s),
    .fill_data_i (bus.mem_data),
    .skip_i      (skip_q),
    .window_o    (window_s),
    .count_o     (count_s)
  );

  assign bus.mem_req    = (state_q != ST_RUN);
  assign bus.mem_addr   = addr_q;
  assign bus.inst_out   = window_s;
  assign bus.inst_pc    = pc_q;
  assign bus.inst_valid = valid_s;

  // Next-state, fetch address and PC; redirect overrides consume and fill
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pend_d  = pend_q;

    case (state_q)
      ST_RUN: begin
        if (bus.redirect) begin
          addr_d  = redir_addr_s;
          state_d = ST_WAIT;
        end else if (count_after_s <= 4'd4) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (bus.mem_ack) begin
          addr_d  = bus.redirect ? redir_addr_s : (addr_q + 64'd8);
          state_d = ST_RUN;
        end else if (bus.redirect) begin
          pend_d  = redir_addr_s;
          state_d = ST_DROP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DROP: begin
        // mem_addr stays on the abandoned address until its ack retires it
        if (bus.mem_ack) begin
          addr_d  = bus.redirect ? redir_addr_s : pend_q;
          state_d = ST_WAIT;
        end else if (bus.redirect) begin
          pend_d  = redir_addr_s;
          state_d = ST_DROP;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (bus.redirect) begin
      pc_d = redir_pc_s;
    end else if (consume_s) begin
      pc_d = pc_q + {59'd0, len_s, 1'b0};
    end else begin
      pc_d = pc_q;
    end

    if (bus.redirect) begin
      skip_d = bus.redirect_pc[2:1];
    end else if (fill_s) begin
      skip_d = 2'd0;
    end else begin
      skip_d = skip_q;
    end
  end

  // FSM and address/PC registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      addr_q  <= RESET_ADDR;
      pend_q  <= RESET_ADDR;
      pc_q    <= RESET_IPC;
      skip_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      pc_q    <= pc_d;
      skip_q  <= skip_d;
    end
  end

`ifdef FETCH_ALIGN_STATS_EN
  logic [31:0] stall_q;

  // Saturating count of cycles where decode is ready but starved
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 32'd0;
    end else if (bus.redirect) begin
      stall_q <= 32'd0;
    end else if (bus.inst_ready && !valid_s && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end else begin
      stall_q <= stall_q;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
